// File: rtl/orb_wr_arbiter_if.sv
// orb_wr_arbiter_if: per-requester write strobes in, shared RAM write port and status out
interface orb_wr_arbiter_if #(
  parameter int N_REQ = 5,
  parameter int AW = 11,
  parameter int DW = 12
);
  logic [N_REQ-1:0] iWE;
  logic [N_REQ*AW-1:0] iAddr;
  logic [N_REQ*DW-1:0] iWord;
  logic [AW-1:0] oWrAddr;
  logic [DW-1:0] oWord;
  logic oWE1;
  logic oWE2;
  logic oBusy;
  logic [N_REQ-1:0] oOvf;
  modport master(output iWE, iAddr, iWord, input oWrAddr, oWord, oWE1, oWE2, oBusy, oOvf);
  modport slave(input iWE, iAddr, iWord, output oWrAddr, oWord, oWE1, oWE2, oBusy, oOvf);
endinterface

// File: rtl/orb_wr_arbiter.sv
// orb_wr_arbiter: round-robin serializer of packer writes into the ping-pong orbital frame RAMs
module orb_wr_arbiter #(
  parameter int N_REQ = 5,
  parameter int AW = 11,
  parameter int DW = 12
) (
  input logic clk,
  input logic rst,
  input logic iSW,
  input logic iClrOvf,
  orb_wr_arbiter_if.slave bus
);
  localparam int PW = N_REQ > 1 ? $clog2(N_REQ) : 1;
  logic swMeta, swS, found;
  logic [N_REQ-1:0] pend, pBank1, gnt, ovfSet;
  logic [AW-1:0] pAddr [N_REQ];
  logic [DW-1:0] pWord [N_REQ];
  logic [PW-1:0] ptr, win, cand;
  // first pending index after the last winner, wrapping modulo N_REQ
  always_comb begin
    win = ptr;
    cand = ptr;
    found = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = PW'((int'(ptr) + i) % N_REQ);
      if (!found && pend[cand]) begin
        win = cand;
        found = 1'b1;
      end
    end
    gnt = found ? N_REQ'(1) << win : '0;
    ovfSet = bus.iWE & pend & ~gnt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      swMeta <= 1'b0;
      swS <= 1'b0;
      pend <= '0;
      ptr <= PW'(N_REQ - 1);
      bus.oWrAddr <= '0;
      bus.oWord <= '0;
      bus.oWE1 <= 1'b0;
      bus.oWE2 <= 1'b0;
      bus.oBusy <= 1'b0;
      bus.oOvf <= '0;
    end else begin
      swMeta <= iSW;
      swS <= swMeta;
      // a granted entry frees its slot this edge, so a same-cycle reload is accepted
      for (int k = 0; k < N_REQ; k++)
        if (bus.iWE[k] && (!pend[k] || gnt[k])) begin
          pAddr[k] <= bus.iAddr[k*AW +: AW];
          pWord[k] <= bus.iWord[k*DW +: DW];
          pBank1[k] <= swS;
        end
      pend <= (pend & ~gnt) | bus.iWE;
      ptr <= found ? win : ptr;
      if (found) begin
        bus.oWrAddr <= pAddr[win];
        bus.oWord <= pWord[win];
      end
      bus.oWE1 <= found & pBank1[win];
      bus.oWE2 <= found & ~pBank1[win];
      bus.oBusy <= |pend | bus.oWE1 | bus.oWE2;
      bus.oOvf <= ovfSet | (iClrOvf ? '0 : bus.oOvf);
    end
  end
endmodule

// File: tb/tb_orb_wr_arbiter.sv
// tb_orb_wr_arbiter: vector table plus corner sequences, writes checked against an expected-write queue
module tb_orb_wr_arbiter;
  logic clk = 1'b0;
  logic rst, iSW, iClrOvf;
  int checks = 0;
  int errors = 0;
  typedef struct packed {logic [10:0] a; logic [11:0] w; logic b1;} exp_t;
  typedef struct packed {logic [4:0] we; logic sw; logic [2:0] n; logic [14:0] ord;} vec_t;
  exp_t q[$];
  exp_t me;
  vec_t v[7];
  orb_wr_arbiter_if #(.N_REQ(5), .AW(11), .DW(12)) bus();
  orb_wr_arbiter #(.N_REQ(5), .AW(11), .DW(12)) dut(.clk(clk), .rst(rst), .iSW(iSW), .iClrOvf(iClrOvf), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [10:0] aOf(int tag, int k);
    return 11'(tag * 8 + k + 10);
  endfunction
  function automatic logic [11:0] wOf(int tag, int k);
    return 12'(tag * 97 + k * 13 + 'h400);
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask
  task automatic drive(logic [4:0] we, int tag);
    for (int k = 0; k < 5; k++) begin
      bus.iAddr[k*11 +: 11] = aOf(tag, k);
      bus.iWord[k*12 +: 12] = wOf(tag, k);
    end
    bus.iWE = we;
  endtask
  task automatic push(int k, int tag, logic b1);
    q.push_back('{aOf(tag, k), wOf(tag, k), b1});
  endtask
  task automatic drain(string nm);
    int t = 0;
    while ((q.size() != 0 || bus.oBusy) && t < 60) begin
      tick();
      t++;
    end
    chk({nm, "_drained"}, q.size(), 0);
    repeat (3) tick();
  endtask
  task automatic doReset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask
  always @(negedge clk)
    if (bus.oWE1 || bus.oWE2) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr=%0d word=%h we1=%b we2=%b, expected no write",
                 bus.oWrAddr, bus.oWord, bus.oWE1, bus.oWE2);
      end else begin
        me = q.pop_front();
        if ({bus.oWrAddr, bus.oWord, bus.oWE1, bus.oWE2} !== {me.a, me.w, me.b1, ~me.b1}) begin
          errors++;
          $display("FAIL write: got addr=%0d word=%h we1=%b we2=%b, expected addr=%0d word=%h we1=%b we2=%b",
                   bus.oWrAddr, bus.oWord, bus.oWE1, bus.oWE2, me.a, me.w, me.b1, ~me.b1);
        end
      end
    end
  initial begin
    v[0] = '{5'b11111, 1'b0, 3'd5, {3'd4, 3'd3, 3'd2, 3'd1, 3'd0}};
    v[1] = '{5'b00101, 1'b1, 3'd2, {9'd0, 3'd2, 3'd0}};
    v[2] = '{5'b10011, 1'b0, 3'd3, {6'd0, 3'd1, 3'd0, 3'd4}};
    v[3] = '{5'b01100, 1'b1, 3'd2, {9'd0, 3'd3, 3'd2}};
    v[4] = '{5'b01010, 1'b0, 3'd2, {9'd0, 3'd3, 3'd1}};
    v[5] = '{5'b10000, 1'b1, 3'd1, {12'd0, 3'd4}};
    v[6] = '{5'b00001, 1'b0, 3'd1, {12'd0, 3'd0}};
    rst = 1'b1;
    iSW = 1'b0;
    iClrOvf = 1'b0;
    bus.iWE = '0;
    bus.iAddr = '0;
    bus.iWord = '0;
    repeat (2) tick();
    chk("rst_we", {bus.oWE1, bus.oWE2}, 0);
    chk("rst_addr_word", {bus.oWrAddr, bus.oWord}, 0);
    chk("rst_ovf_busy", {bus.oOvf, bus.oBusy}, 0);
    rst = 1'b0;
    tick();
    bus.iAddr[10:0] = 11'd100;
    bus.iWord[11:0] = 12'hABC;
    bus.iWE = 5'b00001;
    q.push_back('{11'd100, 12'hABC, 1'b0});
    tick();
    bus.iWE = '0;
    chk("single_n1_idle", {bus.oWE1, bus.oWE2}, 0);
    tick();
    chk("single_n2_we", {bus.oWE1, bus.oWE2}, 2'b01);
    chk("single_n2_data", {bus.oWrAddr, bus.oWord}, {11'd100, 12'hABC});
    tick();
    chk("single_one_pulse", {bus.oWE1, bus.oWE2}, 0);
    drain("single");
    doReset();
    for (int r = 0; r < 7; r++) begin
      iSW = v[r].sw;
      repeat (3) tick();
      drive(v[r].we, r);
      for (int i = 0; i < int'(v[r].n); i++) push(int'(v[r].ord[3*i +: 3]), r, v[r].sw);
      tick();
      bus.iWE = '0;
      drain($sformatf("vec%0d", r));
      chk($sformatf("vec%0d_ovf", r), bus.oOvf, 0);
    end
    doReset();
    push(0, 0, 0); push(1, 0, 0); push(3, 0, 0); push(0, 1, 0); push(0, 4, 0); push(0, 5, 0);
    for (int c = 0; c < 6; c++) begin
      drive(c == 0 ? 5'b01011 : 5'b00001, c);
      tick();
    end
    bus.iWE = '0;
    drain("fair");
    chk("fair_ovf", bus.oOvf, 5'b00001);
    iClrOvf = 1'b1;
    tick();
    iClrOvf = 1'b0;
    chk("fair_ovf_clr", bus.oOvf, 0);
    doReset();
    drive(5'b00111, 20);
    push(0, 20, 0); push(1, 20, 0); push(2, 20, 0);
    tick();
    drive(5'b00100, 21);
    tick();
    bus.iWE = '0;
    drain("ovf");
    chk("ovf_set", bus.oOvf, 5'b00100);
    iClrOvf = 1'b1;
    tick();
    iClrOvf = 1'b0;
    chk("ovf_clr", bus.oOvf, 0);
    drive(5'b00111, 22);
    push(0, 22, 0); push(1, 22, 0); push(2, 22, 0);
    tick();
    drive(5'b00100, 23);
    iClrOvf = 1'b1;
    tick();
    bus.iWE = '0;
    iClrOvf = 1'b0;
    chk("ovf_set_beats_clr", bus.oOvf, 5'b00100);
    drain("ovf2");
    chk("ovf_sticky", bus.oOvf, 5'b00100);
    doReset();
    chk("ovf_rst", bus.oOvf, 0);
    iSW = 1'b1;
    repeat (3) tick();
    drive(5'b11111, 30);
    for (int k = 0; k < 5; k++) push(k, 30, 1);
    tick();
    bus.iWE = '0;
    iSW = 1'b0;
    drain("bank_latch");
    drive(5'b00100, 31);
    push(2, 31, 0);
    tick();
    bus.iWE = '0;
    drain("bank_new");
    doReset();
    drive(5'b01111, 40);
    push(0, 40, 0);
    tick();
    bus.iWE = '0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("midrst_idle", {bus.oWE1, bus.oWE2, bus.oBusy}, 0);
    chk("midrst_queue", q.size(), 0);
    drive(5'b00101, 41);
    push(0, 41, 0); push(2, 41, 0);
    tick();
    bus.iWE = '0;
    drain("midrst_ptr");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
